// File: rtl/fetch_dec_ctrl_if.sv
// Bundle hand-off bus between the fetch packer/redirect logic and decode.
// master = fetch/decode environment, slave = fetch_dec_ctrl.
interface fetch_dec_ctrl_if;
  logic        fetch_vld;
  logic [63:0] pc_in;
  logic [63:0] inst_in;
  logic [63:0] recv_pc_in;
  logic [3:0]  pred_in;
  logic        dec_stall;
  logic        flush;
  logic [15:0] flush_pc;

  logic        start;
  logic        fetch_stall;
  logic        dec_vld;
  logic [63:0] dec_pc;
  logic [63:0] dec_inst;
  logic [63:0] dec_recv_pc;
  logic [3:0]  dec_pred;
  logic        redirect_vld;
  logic [15:0] redirect_pc;

  modport master (
    output fetch_vld, pc_in, inst_in, recv_pc_in, pred_in, dec_stall, flush, flush_pc,
    input  start, fetch_stall, dec_vld, dec_pc, dec_inst, dec_recv_pc, dec_pred,
           redirect_vld, redirect_pc
  );

  modport slave (
    input  fetch_vld, pc_in, inst_in, recv_pc_in, pred_in, dec_stall, flush, flush_pc,
    output start, fetch_stall, dec_vld, dec_pc, dec_inst, dec_recv_pc, dec_pred,
           redirect_vld, redirect_pc
  );
endinterface

// File: rtl/fetch_dec_ctrl.sv
// Fetch-to-decode hand-off: 2-entry bundle buffer, post-reset start window,
// and flush/redirect sequencing on mispredict recovery.
module fetch_dec_ctrl #(
  parameter int START_CYCLES  = 3,
  parameter int FLUSH_BUBBLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_dec_ctrl_if.slave  bus
);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [1:0]   count_q, count_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         redirect_vld_q, redirect_vld_d;
  logic [15:0]  redirect_pc_q, redirect_pc_d;
  logic [195:0] mem_q [2];

  logic         push, pop;
  logic         fetch_stall, dec_vld;
  logic [195:0] head;

  // Stall depends only on registered state so it never combinationally follows dec_stall.
  assign fetch_stall = (state_q != S_RUN) || (count_q == 2'd2);
  assign dec_vld     = (count_q != 2'd0);
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    count_d        = count_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    redirect_vld_d = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    push           = 1'b0;
    pop            = 1'b0;

    if (state_q != S_START && bus.flush) begin
      state_d        = S_FLUSH;
      cnt_d          = 4'(FLUSH_BUBBLES);
      count_d        = 2'd0;
      wr_ptr_d       = 1'b0;
      rd_ptr_d       = 1'b0;
      redirect_vld_d = 1'b1;
      redirect_pc_d  = bus.flush_pc;
    end else begin
      case (state_q)
        S_START, S_FLUSH: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RUN;
        end
        S_RUN: begin
          push = bus.fetch_vld && !fetch_stall;
          pop  = dec_vld && !bus.dec_stall;
          if (push) wr_ptr_d = ~wr_ptr_q;
          if (pop)  rd_ptr_d = ~rd_ptr_q;
          count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
        default: state_d = S_START;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_START;
      cnt_q          <= 4'(START_CYCLES);
      count_q        <= 2'd0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  // Storage needs no reset: every read is gated by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.pc_in, bus.inst_in, bus.recv_pc_in, bus.pred_in};
  end

  assign bus.start        = (state_q == S_START);
  assign bus.fetch_stall  = fetch_stall;
  assign bus.dec_vld      = dec_vld;
  assign bus.dec_pc       = dec_vld ? head[195:132] : 64'd0;
  assign bus.dec_inst     = dec_vld ? head[131:68]  : 64'd0;
  assign bus.dec_recv_pc  = dec_vld ? head[67:4]    : 64'd0;
  assign bus.dec_pred     = dec_vld ? head[3:0]     : 4'd0;
  assign bus.redirect_vld = redirect_vld_q;
  assign bus.redirect_pc  = redirect_pc_q;

endmodule

// File: tb/tb_fetch_dec_ctrl.sv
// Scoreboard bench for fetch_dec_ctrl: a cycle-count/queue reference model
// predicts accepted bundles and control outputs; a negedge monitor compares.
module tb_fetch_dec_ctrl;
  localparam int SC = 3;
  localparam int FB = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_dec_ctrl_if bus();

  fetch_dec_ctrl #(.START_CYCLES(SC), .FLUSH_BUBBLES(FB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] inst;
    logic [63:0] rpc;
    logic [3:0]  pred;
  } bundle_t;

  bundle_t     exp_q[$];
  int          start_left  = SC;
  int          bubble_left = 0;
  int          occ         = 0;
  logic        exp_redir   = 1'b0;
  logic [15:0] exp_rpc     = 16'd0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: start window and bubble window as countdowns, buffer as a queue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      start_left  = SC;
      bubble_left = 0;
      exp_redir   = 1'b0;
      exp_rpc     = 16'd0;
    end else begin
      exp_redir = 1'b0;
      if (start_left > 0) begin
        start_left--;
      end else if (bus.flush) begin
        exp_q.delete();
        bubble_left = FB;
        exp_redir   = 1'b1;
        exp_rpc     = bus.flush_pc;
      end else if (bubble_left > 0) begin
        bubble_left--;
      end else if (bus.fetch_vld && occ < 2) begin
        exp_q.push_back('{pc: bus.pc_in, inst: bus.inst_in, rpc: bus.recv_pc_in, pred: bus.pred_in});
      end
    end
  end

  // Monitor: compares every cycle and retires the head when decode takes it.
  always @(negedge clk) begin
    occ = exp_q.size();
    chk("start",        64'(bus.start),        64'(start_left > 0));
    chk("fetch_stall",  64'(bus.fetch_stall),  64'(start_left > 0 || bubble_left > 0 || occ == 2));
    chk("dec_vld",      64'(bus.dec_vld),      64'(occ != 0));
    chk("redirect_vld", 64'(bus.redirect_vld), 64'(exp_redir));
    chk("redirect_pc",  64'(bus.redirect_pc),  64'(exp_rpc));
    if (occ != 0) begin
      chk("dec_pc",      bus.dec_pc,           exp_q[0].pc);
      chk("dec_inst",    bus.dec_inst,         exp_q[0].inst);
      chk("dec_recv_pc", bus.dec_recv_pc,      exp_q[0].rpc);
      chk("dec_pred",    64'(bus.dec_pred),    64'(exp_q[0].pred));
      if (rst_n && !bus.dec_stall && !bus.flush) begin
        n_pop++;
        $display("pop %0d pc=%h pred=%h", n_pop, exp_q[0].pc, exp_q[0].pred);
        void'(exp_q.pop_front());
      end
    end else begin
      chk("dec_pc_idle",   bus.dec_pc,        64'd0);
      chk("dec_inst_idle", bus.dec_inst,      64'd0);
      chk("dec_rpc_idle",  bus.dec_recv_pc,   64'd0);
      chk("dec_pred_idle", 64'(bus.dec_pred), 64'd0);
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic cyc(input bit fv, input bit ds, input bit fl,
                     input logic [15:0] fpc, input logic [63:0] pc);
    bus.fetch_vld  = fv;
    bus.dec_stall  = ds;
    bus.flush      = fl;
    bus.flush_pc   = fpc;
    bus.pc_in      = pc;
    bus.inst_in    = rnd64();
    bus.recv_pc_in = rnd64();
    bus.pred_in    = 4'($urandom());
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.fetch_vld  = 1'b0;
    bus.dec_stall  = 1'b0;
    bus.flush      = 1'b0;
    bus.flush_pc   = 16'd0;
    bus.pc_in      = 64'd0;
    bus.inst_in    = 64'd0;
    bus.recv_pc_in = 64'd0;
    bus.pred_in    = 4'd0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // start window, fetch offered but must not be taken
    repeat (SC) cyc(1, 0, 0, 16'd0, rnd64());
    // first bundle then streaming
    cyc(1, 0, 0, 16'd0, 64'h0000_0001_0002_0003);
    repeat (5) cyc(1, 0, 0, 16'd0, rnd64());
    cyc(0, 0, 0, 16'd0, rnd64());
    // decode back-pressure fills the buffer, then drains in order
    repeat (4) cyc(1, 1, 0, 16'd0, rnd64());
    repeat (3) cyc(0, 0, 0, 16'd0, rnd64());
    // push and pop together at count 1
    cyc(1, 0, 0, 16'd0, rnd64());
    cyc(1, 0, 0, 16'd0, rnd64());
    cyc(0, 0, 0, 16'd0, rnd64());
    // flush with a full buffer
    repeat (3) cyc(1, 1, 0, 16'd0, rnd64());
    cyc(1, 1, 1, 16'h0040, rnd64());
    repeat (4) cyc(1, 0, 0, 16'd0, rnd64());
    // back-to-back flushes, then async reset in the middle of FLUSH
    cyc(1, 0, 1, 16'h0010, rnd64());
    cyc(1, 0, 1, 16'h0020, rnd64());
    cyc(1, 0, 0, 16'd0, rnd64());
    rst_n = 1'b0;
    repeat (2) cyc(1, 0, 0, 16'd0, rnd64());
    rst_n = 1'b1;
    // randomized traffic with occasional flushes
    repeat (500) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 24) == 0, 16'($urandom()), rnd64());
    bus.fetch_vld = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
